// File: rtl/fifo_stat_pkg.sv
// fifo_stat_pkg: read-mode constants and count-width helper shared by the FIFO files
package fifo_stat_pkg;
   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/fifo_stat_if.sv
// fifo_stat_if: push/pop handshake plus fill-level and error status of one FIFO
interface fifo_stat_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 6
);
   import fifo_stat_pkg::*;
   logic                                     clear, write, read;
   logic [DATA_WIDTH-1:0]                    write_data, read_data;
   logic                                     read_valid, empty, full, almost_empty, almost_full;
   logic                                     overflow, underflow;
   logic [cnt_width(2**ADDRESS_WIDTH)-1:0]   count;
   modport master (
      output clear, write, write_data, read,
      input  read_data, read_valid, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
   modport slave (
      input  clear, write, write_data, read,
      output read_data, read_valid, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_stat_ram.sv
// fifo_stat_ram: simple dual-port RAM, one write port and one enabled synchronous read port
module fifo_stat_ram #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [ADDRESS_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0]    i_wdata,
   input  logic                     i_re,
   input  logic [ADDRESS_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0]    o_rdata
);
   logic [DATA_WIDTH-1:0] r_mem [2**ADDRESS_WIDTH];
   logic [DATA_WIDTH-1:0] r_rdata;
   // store pushed words
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   // read-before-write, so a same-address pop while full still returns the old word
   always_ff @(posedge clk) begin
      if (i_re) r_rdata <= r_mem[i_raddr];
   end
   assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo_stat.sv
// fifo_stat: single-clock FIFO with occupancy count, level flags, sticky errors, flush and optional FWFT
module fifo_stat
   import fifo_stat_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 6,
   parameter int FWFT          = FIFO_MODE_STD,
   parameter int AFULL_LEVEL   = 2**ADDRESS_WIDTH - 4,
   parameter int AEMPTY_LEVEL  = 4
) (
   input logic        clk,
   input logic        reset,
   fifo_stat_if.slave io_bus
);
   localparam int DEPTH = 2**ADDRESS_WIDTH;
   localparam int CW    = cnt_width(DEPTH);
   localparam bit FW    = (FWFT == FIFO_MODE_FWFT);
   logic [ADDRESS_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]            r_count, w_count_nxt, w_ram_cnt;
   logic                     r_empty, r_full, r_aempty, r_afull, r_ovf, r_udf;
   logic                     r_rvalid, r_pend;
   logic [DATA_WIDTH-1:0]    r_dout, w_ram_rdata;
   logic                     w_wr_ok, w_rd_ok, w_out_free, w_issue, w_bypass, w_ram_we;
   // accept decisions, next count and FWFT prefetch control
   always_comb begin
      w_rd_ok     = io_bus.read & (FW ? r_rvalid : ~r_empty);
      w_wr_ok     = io_bus.write & (~r_full | w_rd_ok);
      w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
      w_ram_cnt   = r_count - CW'(r_rvalid) - CW'(r_pend);
      w_out_free  = ~r_rvalid | w_rd_ok;
      w_issue     = FW ? (w_ram_cnt != '0) & (w_out_free | ~r_pend) : w_rd_ok;
      w_bypass    = FW & w_out_free & ~r_pend & (w_ram_cnt == '0) & w_rd_ok & w_wr_ok;
      w_ram_we    = w_wr_ok & ~w_bypass;
   end
   // pointers, count, registered flags and read-valid/prefetch state
   always_ff @(posedge clk) begin
      if (reset | io_bus.clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rvalid <= 1'b0;
         r_pend   <= 1'b0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_aempty <= 1'b1;
         r_afull  <= (AFULL_LEVEL == 0);
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_ram_we) r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
         if (w_issue) r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
         r_count  <= w_count_nxt;
         r_empty  <= (w_count_nxt == '0);
         r_full   <= (32'(w_count_nxt) == DEPTH);
         r_aempty <= (32'(w_count_nxt) <= AEMPTY_LEVEL);
         r_afull  <= (32'(w_count_nxt) >= AFULL_LEVEL);
         r_ovf    <= r_ovf | (io_bus.write & ~w_wr_ok);
         r_udf    <= r_udf | (io_bus.read & ~w_rd_ok);
         r_pend   <= FW & (w_issue | (r_pend & ~w_out_free));
         r_rvalid <= FW ? (w_out_free ? r_pend | w_bypass : r_rvalid) : w_rd_ok;
      end
   end
   // FWFT output word: refilled from RAM, or straight from the push when streaming at count 1
   always_ff @(posedge clk) begin
      if (FW & w_out_free) r_dout <= r_pend ? w_ram_rdata : io_bus.write_data;
   end
   fifo_stat_ram #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_ram (
      .clk    (clk),
      .i_we   (w_ram_we),
      .i_waddr(r_wr_ptr),
      .i_wdata(io_bus.write_data),
      .i_re   (w_issue),
      .i_raddr(r_rd_ptr),
      .o_rdata(w_ram_rdata)
   );
   assign io_bus.read_data    = FW ? r_dout : w_ram_rdata;
   assign io_bus.read_valid   = r_rvalid;
   assign io_bus.empty        = r_empty;
   assign io_bus.full         = r_full;
   assign io_bus.almost_empty = r_aempty;
   assign io_bus.almost_full  = r_afull;
   assign io_bus.count        = r_count;
   assign io_bus.overflow     = r_ovf;
   assign io_bus.underflow    = r_udf;
endmodule
